// File: rtl/alu_pkg.sv
// Shared constants and FSM state encoding for alu_arbiter and the alu it fronts.
package alu_pkg;

  localparam int unsigned ALU_DATA_WIDTH = 8;
  localparam int unsigned ALU_OP_WIDTH   = 4;
  localparam int unsigned ALU_MAX_OPCODE = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } alu_arb_state_e;

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester that was not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic       grant_o,
  output logic       any_o
);

  always_comb begin
    any_o = |valid_i;
    if (&valid_i) begin
      grant_o = ~last_i;
    end else begin
      grant_o = valid_i[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional opcode range check enabled by `define ALU_ARB_OPCODE_CHECK_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int unsigned OP_WIDTH   = ALU_OP_WIDTH,
  parameter int unsigned MAX_OPCODE = ALU_MAX_OPCODE
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [1:0]            REQ_VALID,
  output logic [1:0]            REQ_READY,
  input  logic [OP_WIDTH-1:0]   REQ_OPCODE0,
  input  logic [OP_WIDTH-1:0]   REQ_OPCODE1,
  input  logic [DATA_WIDTH-1:0] REQ_A0,
  input  logic [DATA_WIDTH-1:0] REQ_A1,
  input  logic [DATA_WIDTH-1:0] REQ_B0,
  input  logic [DATA_WIDTH-1:0] REQ_B1,
  output logic [1:0]            RSP_VALID,
  input  logic [1:0]            RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_RESULT,
  output logic                  RSP_ERR,
  output logic [OP_WIDTH-1:0]   ALU_OPCODE,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  input  logic [DATA_WIDTH-1:0] ALU_RESULT
);

  alu_arb_state_e        state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic                  owner_q, owner_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;

  logic                  grant;
  logic                  req_any;
  logic [OP_WIDTH-1:0]   sel_op;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;

  rr_arbiter2 u_rr (
    .valid_i (REQ_VALID),
    .last_i  (ptr_q),
    .grant_o (grant),
    .any_o   (req_any)
  );

  assign sel_op = grant ? REQ_OPCODE1 : REQ_OPCODE0;
  assign sel_a  = grant ? REQ_A1 : REQ_A0;
  assign sel_b  = grant ? REQ_B1 : REQ_B0;

`ifdef ALU_ARB_OPCODE_CHECK_EN
  logic err_q, err_d;
  logic op_illegal;
  assign op_illegal = sel_op > OP_WIDTH'(MAX_OPCODE);
`else
  logic unused_max_opcode;
  assign unused_max_opcode = ^MAX_OPCODE;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    REQ_READY = '0;
    RSP_VALID = '0;
`ifdef ALU_ARB_OPCODE_CHECK_EN
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        // Ready follows valid for the granted requester, so any valid is a handshake.
        if (req_any) begin
          REQ_READY[grant] = 1'b1;
          owner_d          = grant;
          ptr_d            = grant;
`ifdef ALU_ARB_OPCODE_CHECK_EN
          if (op_illegal) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            op_d    = sel_op;
            a_d     = sel_a;
            b_d     = sel_b;
            state_d = EXEC;
          end
`else
          op_d    = sel_op;
          a_d     = sel_a;
          b_d     = sel_b;
          state_d = EXEC;
`endif
        end
      end
      EXEC: begin
        res_d   = ALU_RESULT;
        state_d = RESP;
      end
      RESP: begin
        RSP_VALID[owner_q] = 1'b1;
        if (RSP_READY[owner_q]) begin
          state_d = IDLE;
`ifdef ALU_ARB_OPCODE_CHECK_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (!RST_N) begin
      REQ_READY = '0;
      RSP_VALID = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      owner_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
`ifdef ALU_ARB_OPCODE_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
`ifdef ALU_ARB_OPCODE_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

`ifdef ALU_ARB_OPCODE_CHECK_EN
  assign RSP_ERR = err_q;
`else
  assign RSP_ERR = 1'b0;
`endif

  assign RSP_RESULT = res_q;
  assign ALU_OPCODE = op_q;
  assign ALU_A      = a_q;
  assign ALU_B      = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with an ALU stub computing A + B + OPCODE.
module tb_alu_arbiter;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [1:0] REQ_VALID = 2'b00;
  logic [1:0] REQ_READY;
  logic [3:0] op0 = '0, op1 = '0;
  logic [7:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [1:0] RSP_VALID;
  logic [1:0] RSP_READY = 2'b11;
  logic [7:0] RSP_RESULT;
  logic       RSP_ERR;
  logic [3:0] ALU_OPCODE;
  logic [7:0] ALU_A, ALU_B, ALU_RESULT;

  assign ALU_RESULT = ALU_A + ALU_B + {4'b0000, ALU_OPCODE};

  alu_arbiter #(.DATA_WIDTH(8), .OP_WIDTH(4), .MAX_OPCODE(11)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OPCODE0(op0), .REQ_OPCODE1(op1),
    .REQ_A0(a0), .REQ_A1(a1), .REQ_B0(b0), .REQ_B1(b1),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RESULT(RSP_RESULT), .RSP_ERR(RSP_ERR),
    .ALU_OPCODE(ALU_OPCODE), .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_RESULT(ALU_RESULT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         idx;
    logic [7:0] res;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   seen  = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: compares every presented response against the scoreboard head.
  always @(negedge CLK) begin
    if (RST_N && RSP_VALID != 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'(RSP_VALID), 32'd0);
      end else begin
        if (!seen) begin
          check("rsp_latency", cyc, sb[0].cyc);
          seen = 1'b1;
        end
        check("rsp_valid", 32'(RSP_VALID), 32'(1) << sb[0].idx);
        check("rsp_result", 32'(RSP_RESULT), 32'(sb[0].res));
        check("rsp_err", 32'(RSP_ERR), 32'(sb[0].err));
        if (RSP_READY[sb[0].idx]) begin
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input int idx, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] res, input logic err,
                       input int lat, input bit push);
    bit ok;
    @(posedge CLK); #1;
    if (idx == 0) begin op0 = op; a0 = a; b0 = b; end
    else          begin op1 = op; a1 = a; b1 = b; end
    REQ_VALID[idx] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (REQ_READY[idx]) begin ok = 1'b1; break; end
    end
    check($sformatf("accept_req%0d", idx), 32'(ok), 32'd1);
    if (ok) begin
      grant_log.push_back(idx);
      if (push) sb.push_back('{idx, res, err, cyc + lat});
    end
    @(posedge CLK); #1;
    REQ_VALID[idx] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      @(negedge CLK);
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic check_log(input string name, input int exp_q[$]);
    check({name, "_len"}, grant_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < grant_log.size(); i++)
      check($sformatf("%s_%0d", name, i), grant_log[i], exp_q[i]);
    grant_log.delete();
  endtask

  // Directed pair table: {op, a, b, expected} with hand-computed results (mod 256).
  logic [3:0] t_op0 [4] = '{4'd1, 4'd2, 4'd5, 4'd0};
  logic [7:0] t_a0  [4] = '{8'd10, 8'd20, 8'd200, 8'd255};
  logic [7:0] t_b0  [4] = '{8'd2, 8'd3, 8'd60, 8'd1};
  logic [7:0] t_r0  [4] = '{8'd13, 8'd25, 8'd9, 8'd0};
  logic [3:0] t_op1 [4] = '{4'd2, 4'd15, 4'd4, 4'd9};
  logic [7:0] t_a1  [4] = '{8'd7, 8'd0, 8'd128, 8'd50};
  logic [7:0] t_b1  [4] = '{8'd7, 8'd0, 8'd128, 8'd25};
  logic [7:0] t_r1  [4] = '{8'd16, 8'd15, 8'd4, 8'd84};

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, with both requesters asserting valid during reset.
    REQ_VALID = 2'b11;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", 32'(REQ_READY), 32'd0);
    check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("rst_rsp_err", 32'(RSP_ERR), 32'd0);
    check("rst_alu_op", 32'(ALU_OPCODE), 32'd0);
    check("rst_alu_a", 32'(ALU_A), 32'd0);
    check("rst_alu_b", 32'(ALU_B), 32'd0);
    check("rst_rsp_result", 32'(RSP_RESULT), 32'd0);
    @(posedge CLK); #1;
    REQ_VALID = 2'b00;
    RST_N = 1'b1;

    // Simultaneous requests after reset, then back-to-back pairs.
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) issue(0, t_op0[i], t_a0[i], t_b0[i], t_r0[i], 1'b0, 2, 1'b1);
      end
      begin
        for (int i = 0; i < 4; i++) issue(1, t_op1[i], t_a1[i], t_b1[i], t_r1[i], 1'b0, 2, 1'b1);
      end
    join
    drain();
    check_log("alternate", '{0, 1, 0, 1, 0, 1, 0, 1});

    // Single request.
    issue(0, 4'd3, 8'd42, 8'd5, 8'd50, 1'b0, 2, 1'b1);
    drain();
    grant_log.delete();

    // Response backpressure on requester 1 while requester 0 waits.
    @(posedge CLK); #1;
    RSP_READY = 2'b01;
    issue(1, 4'd6, 8'd30, 8'd40, 8'd76, 1'b0, 2, 1'b1);
    op0 = 4'd1; a0 = 8'd1; b0 = 8'd1;
    REQ_VALID[0] = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("bp_rsp_valid", 32'(RSP_VALID), 32'd2);
      check("bp_rsp_result", 32'(RSP_RESULT), 32'd76);
      check("bp_req_ready", 32'(REQ_READY), 32'd0);
    end
    @(posedge CLK); #1;
    RSP_READY = 2'b11;
    issue(0, 4'd1, 8'd1, 8'd1, 8'd3, 1'b0, 2, 1'b1);
    drain();
    check_log("bp_order", '{1, 0});

    // Reset during EXEC aborts the op and restores the tie-break pointer.
    issue(0, 4'd4, 8'd9, 8'd9, 8'd22, 1'b0, 2, 1'b0);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("abort_no_rsp", 32'(RSP_VALID), 32'd0);
    end
    grant_log.delete();
    fork
      issue(0, 4'd7, 8'd1, 8'd2, 8'd10, 1'b0, 2, 1'b1);
      issue(1, 4'd8, 8'd3, 8'd4, 8'd15, 1'b0, 2, 1'b1);
    join
    drain();
    check_log("post_rst", '{0, 1});

    // Out-of-range opcode.
`ifdef ALU_ARB_OPCODE_CHECK_EN
    issue(0, 4'd12, 8'd1, 8'd1, 8'd0, 1'b1, 1, 1'b1);
    check("badop_alu_op_held", 32'(ALU_OPCODE), 32'd8);
    check("badop_alu_a_held", 32'(ALU_A), 32'd3);
`else
    issue(0, 4'd12, 8'd1, 8'd1, 8'd14, 1'b0, 2, 1'b1);
    check("op12_alu_op", 32'(ALU_OPCODE), 32'd12);
`endif
    drain();
    @(negedge CLK);
    check("err_cleared", 32'(RSP_ERR), 32'd0);
    grant_log.delete();

    repeat (3) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
